// File: rtl/io_map_pkg.sv
// Shared IO-region address map and display constants for the CPU memory-mapped peripherals.
package io_map_pkg;

    localparam int unsigned IO_BASE_BIT = 8;
    localparam int unsigned IO_SW_BIT   = 5;

    localparam logic [2:0] OFF_LED  = 3'h1;
    localparam logic [2:0] OFF_HEXV = 3'h2;
    localparam logic [2:0] OFF_CTRL = 3'h3;
    localparam logic [2:0] OFF_WCNT = 3'h4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/dec7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module dec7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/mmio_display_out.sv
// Memory-mapped LED / seven-segment output registers with one write per CPU store strobe,
// combinational readback, and a blinking, maskable registered display path.
module mmio_display_out
    import io_map_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 12_500_000,
    parameter int unsigned WCNT_W    = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        io_we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int unsigned PRE_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic              we_q, we_d;
    logic [9:0]        led_q, led_d;
    logic [23:0]       hexv_q, hexv_d;
    logic [5:0]        mask_q, mask_d;
    logic              blink_en_q, blink_en_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              blink_off_q, blink_off_d;
    logic [5:0][6:0]   seg_q, seg_d;
    logic [5:0][6:0]   dec_seg;

    logic [2:0] off;
    logic       in_region;
    logic       accept;
    logic       unused_bits;

    assign off       = addr[4:2];
    assign in_region = addr[IO_BASE_BIT] & ~addr[IO_SW_BIT];
    assign unused_bits = ^{addr[31:9], addr[7:6], addr[1:0], wdata[31:24]};

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_dec
            dec7seg u_dec (
                .nibble (hexv_q[4*g +: 4]),
                .seg    (dec_seg[g])
            );
        end
    endgenerate

    // Rising-edge detect on the strobe: a store held high for many cycles lands once.
    always_comb begin
        we_d        = io_we;
        led_d       = led_q;
        hexv_d      = hexv_q;
        mask_d      = mask_q;
        blink_en_d  = blink_en_q;
        wcnt_d      = wcnt_q;
        presc_d     = presc_q + 1'b1;
        blink_off_d = blink_off_q;
        seg_d       = seg_q;

        accept = io_we & ~we_q & in_region
               & ((off == OFF_LED) | (off == OFF_HEXV) | (off == OFF_CTRL));

        if (accept) begin
            wcnt_d = wcnt_q + 1'b1;
            case (off)
                OFF_LED:  led_d  = wdata[9:0];
                OFF_HEXV: hexv_d = wdata[23:0];
                OFF_CTRL: begin
                    mask_d     = wdata[5:0];
                    blink_en_d = wdata[8];
                end
                default: ;
            endcase
        end

        if (presc_q == PRE_W'(BLINK_DIV - 1)) begin
            presc_d     = '0;
            blink_off_d = ~blink_off_q;
        end

        for (int unsigned i = 0; i < 6; i++) begin
            seg_d[i] = (mask_q[i] && !(blink_en_q && blink_off_q)) ? dec_seg[i] : SEG_BLANK;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            we_q        <= 1'b1;
            led_q       <= '0;
            hexv_q      <= '0;
            mask_q      <= '1;
            blink_en_q  <= 1'b0;
            wcnt_q      <= '0;
            presc_q     <= '0;
            blink_off_q <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) seg_q[i] <= SEG_ZERO;
        end else begin
            we_q        <= we_d;
            led_q       <= led_d;
            hexv_q      <= hexv_d;
            mask_q      <= mask_d;
            blink_en_q  <= blink_en_d;
            wcnt_q      <= wcnt_d;
            presc_q     <= presc_d;
            blink_off_q <= blink_off_d;
            seg_q       <= seg_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (in_region) begin
            case (off)
                OFF_LED:  rdata[9:0]  = led_q;
                OFF_HEXV: rdata[23:0] = hexv_q;
                OFF_CTRL: rdata[8:0]  = {blink_en_q, 2'b00, mask_q};
                OFF_WCNT: rdata[WCNT_W-1:0] = wcnt_q;
                default:  rdata = '0;
            endcase
        end
    end

    assign LEDR = led_q;
    assign HEX0 = seg_q[0];
    assign HEX1 = seg_q[1];
    assign HEX2 = seg_q[2];
    assign HEX3 = seg_q[3];
    assign HEX4 = seg_q[4];
    assign HEX5 = seg_q[5];

endmodule
